// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state, field positions and entry type for the fetch stage.
// Halt-opcode support (FS_HALT) is only used when FETCH_HALT_EN is defined.
package fetch_pkg;
  localparam int PC_W   = 3;
  localparam int INST_W = 16;

  localparam int COND_MSB = 15;
  localparam int COND_LSB = 14;
  localparam int OPCD_MSB = 13;
  localparam int OPCD_LSB = 10;

  localparam logic [3:0] HALT_OPCODE = 4'b1111;

  typedef enum logic {
    FS_RUN,
    FS_HALT
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [3:0] opcode_of(input logic [INST_W-1:0] i);
    return i[OPCD_MSB:OPCD_LSB];
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small synchronous FIFO of {pc, inst} prefetch entries.
// Flush empties it in one cycle and takes priority over push/pop.
module fetch_queue #(
  parameter int W     = 19,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  assign rdata = mem[rptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, credit-limited ROM reads, kill bit and prefetch queue.
// Define FETCH_HALT_EN to stop fetching after an opcode-1111 instruction.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH   = PC_W,
  parameter int INST_WIDTH = INST_W,
  parameter int DEPTH      = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  fetch_en,
  output logic                  rom_rd_en,
  output logic [PC_WIDTH-1:0]   rom_addr,
  input  logic [INST_WIDTH-1:0] rom_data,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   inst_pc,
  output logic                  halted
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = PC_WIDTH + INST_WIDTH;

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] ret_pc;
  logic                inflight;
  logic                killed;
  logic                run;
  logic                halt_hit;
  logic                push;
  logic                pop;
  logic                issue;
  logic [CW-1:0]       count;
  logic [EW-1:0]       head;

  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign push       = inflight && !killed && !redirect_valid;
  assign rom_addr   = pc;
  assign rom_rd_en  = issue;
  assign {inst_pc, inst} = head;

  // a same-cycle pop frees a slot, so a steady stream gets one read per cycle
  assign issue = reset_n && run && fetch_en && !redirect_valid &&
    (({1'b0, count} + (CW+1)'(inflight)) <
     ((CW+1)'(DEPTH) + (CW+1)'(pop)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= '0;
      ret_pc   <= '0;
      inflight <= 1'b0;
      killed   <= 1'b0;
    end else begin
      inflight <= issue;
      killed   <= issue && halt_hit;
      if (issue) ret_pc <= pc;
      if (redirect_valid) pc <= redirect_pc;
      else if (issue)     pc <= pc + PC_WIDTH'(1);
    end
  end

`ifdef FETCH_HALT_EN
  fetch_state_e state;
  logic         halt_q;

  assign halt_hit = push && (rom_data[OPCD_MSB:OPCD_LSB] == HALT_OPCODE);
  assign run      = (state == FS_RUN);
  assign halted   = halt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= FS_RUN;
      halt_q <= 1'b0;
    end else begin
      unique case (state)
        FS_RUN: if (halt_hit) begin
          state  <= FS_HALT;
          halt_q <= 1'b1;
        end
        FS_HALT: if (redirect_valid) begin
          state  <= FS_RUN;
          halt_q <= 1'b0;
        end
      endcase
    end
  end
`else
  assign halt_hit = 1'b0;
  assign run      = 1'b1;
  assign halted   = 1'b0;
`endif

  fetch_queue #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wdata   ({ret_pc, rom_data}),
    .rdata   (head),
    .count   (count)
  );
endmodule
